// File: rtl/pixel_write_queue.sv
// Pixel write FIFO between the MCU register interface and the memory manager.
// Optional `PIXEL_QUEUE_COALESCE_EN merges same-address writes into the tail-most entry.
module pixel_write_queue #(
    parameter int DEPTH         = 8,
    parameter int ADDRESS_WIDTH = 17,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDRESS_WIDTH-1:0]   inAddress,
    input  logic [DATA_WIDTH-1:0]      inData,
    input  logic                       inWriteRequest,
    output logic                       inWriteComplete,
    output logic [ADDRESS_WIDTH-1:0]   outAddress,
    output logic [DATA_WIDTH-1:0]      outData,
    output logic                       outWriteRequest,
    input  logic                       outWriteComplete,
    output logic [$clog2(DEPTH+1)-1:0] queueLevel,
    output logic                       queueFull,
    output logic                       queueEmpty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic {IDLE, ISSUE} state_t;

    logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0]    data_mem [DEPTH];
    logic [PW-1:0]            head, tail, last;
    logic [LW-1:0]            level_next;
    logic                     armed, offer, push, pop, coalesce;
    state_t                   state;

    assign last  = tail - 1'b1;
    assign offer = inWriteRequest && armed;
    assign pop   = (state == ISSUE) && outWriteComplete;

`ifdef PIXEL_QUEUE_COALESCE_EN
    // A lone entry is the head, which is either being loaded or issued; never merge into it.
    assign coalesce = offer && !queueEmpty && (queueLevel != LW'(1))
                      && (addr_mem[last] == inAddress);
`else
    assign coalesce = 1'b0;
`endif

    // A completing head frees its slot on the same edge, so a full queue can still accept.
    assign push       = offer && !coalesce && (!queueFull || pop);
    assign level_next = queueLevel + LW'(push) - LW'(pop);

    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[tail] <= inAddress;
            data_mem[tail] <= inData;
        end else if (coalesce) begin
            data_mem[last] <= inData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head            <= '0;
            tail            <= '0;
            queueLevel      <= '0;
            queueFull       <= 1'b0;
            queueEmpty      <= 1'b1;
            armed           <= 1'b1;
            inWriteComplete <= 1'b0;
            state           <= IDLE;
            outWriteRequest <= 1'b0;
            outAddress      <= '0;
            outData         <= '0;
        end else begin
            inWriteComplete <= push || coalesce;
            if (!inWriteRequest)
                armed <= 1'b1;
            else if (push || coalesce)
                armed <= 1'b0;

            if (push)
                tail <= tail + 1'b1;
            queueLevel <= level_next;
            queueFull  <= (level_next == LW'(DEPTH));
            queueEmpty <= (level_next == '0);

            case (state)
                IDLE: begin
                    if (!queueEmpty) begin
                        outAddress      <= addr_mem[head];
                        outData         <= data_mem[head];
                        outWriteRequest <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (outWriteComplete) begin
                        head            <= head + 1'b1;
                        outWriteRequest <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
